// File: rtl/mp1_mem_pkg.sv
// Shared types and constants for the mp1 memory responder.
package mp1_mem_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;
    typedef logic [1:0]  state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam int ERR_RW  = 0;
    localparam int ERR_CHG = 1;
    localparam int ERR_BD  = 2;

endpackage

// File: rtl/mp1_mem_array.sv
// Single-port word array with byte-lane writes and a registered read port.
module mp1_mem_array
    import mp1_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  be_t           be,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    input  logic          re,
    input  logic          clr,
    output word_t         rdata
);

    word_t mem_r [DEPTH];
    word_t rdata_r;

    // storage update; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // read register: cleared on reset or on demand, otherwise held between reads
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (clr) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mp1_mem_responder.sv
// Target side of the mp1 mem_read/mem_write/mem_resp handshake with programmable
// latency, sticky protocol-violation flags and a backdoor preload port.
module mp1_mem_responder
    import mp1_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  be_t                      mem_byte_enable,
    input  logic [31:0]              mem_address,
    input  word_t                    mem_wdata,
    output logic                     mem_resp,
    output word_t                    mem_rdata,
    input  logic                     bd_we,
    input  logic [$clog2(DEPTH)-1:0] bd_addr,
    input  word_t                    bd_wdata,
    output logic                     busy,
    output logic [2:0]               err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [31:0]   addr_r;
    word_t         wdata_r;
    be_t           be_r;
    logic          read_r, write_r;
    logic          resp_r, busy_r;
    logic [2:0]    err_r, err_s;

    logic          req_s, accept_s, fire_s, chg_s, bd_ok_s, bd_drop_s;
    logic          arr_we_s, arr_re_s, arr_clr_s;
    be_t           arr_be_s;
    logic [AW-1:0] arr_addr_s;
    word_t         arr_wdata_s;

    // handshake sequencing and violation detection
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        fire_s   = 1'b0;
        req_s    = mem_read | mem_write;
        chg_s    = (mem_read != read_r) | (mem_write != write_r) |
                   (mem_address != addr_r) | (mem_wdata != wdata_r) |
                   (mem_byte_enable != be_r);
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    accept_s = 1'b1;
                    state_s  = WAIT;
                    cnt_s    = CNT_LOAD;
                end else begin
                    state_s  = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    fire_s  = 1'b1;
                    state_s = RESP;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            // a request still asserted here is the one just answered
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase

        bd_ok_s   = bd_we & (state_r == IDLE) & ~req_s;
        bd_drop_s = bd_we & ~bd_ok_s;

        err_s          = err_r;
        err_s[ERR_RW]  = err_r[ERR_RW]  | (accept_s & mem_read & mem_write);
        err_s[ERR_CHG] = err_r[ERR_CHG] | ((state_r == WAIT) & chg_s);
        err_s[ERR_BD]  = err_r[ERR_BD]  | bd_drop_s;
    end

    // array port mux: protocol access at the response edge, otherwise backdoor
    always_comb begin
        arr_we_s  = rst & (bd_ok_s | (fire_s & write_r & ~read_r));
        arr_re_s  = fire_s & read_r & ~write_r;
        arr_clr_s = fire_s & read_r & write_r;
        if (fire_s) begin
            arr_addr_s  = addr_r[AW+1:2];
            arr_be_s    = be_r;
            arr_wdata_s = wdata_r;
        end else begin
            arr_addr_s  = bd_addr;
            arr_be_s    = 4'b1111;
            arr_wdata_s = bd_wdata;
        end
    end

    // state, request capture and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            resp_r  <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 3'b000;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'b0000;
            read_r  <= 1'b0;
            write_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            resp_r  <= fire_s;
            busy_r  <= (state_s != IDLE);
            err_r   <= err_s;
            if (accept_s) begin
                addr_r  <= mem_address;
                wdata_r <= mem_wdata;
                be_r    <= mem_byte_enable;
                read_r  <= mem_read;
                write_r <= mem_write;
            end
        end
    end

    mp1_mem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we_s),
        .be    (arr_be_s),
        .addr  (arr_addr_s),
        .wdata (arr_wdata_s),
        .re    (arr_re_s),
        .clr   (arr_clr_s),
        .rdata (mem_rdata)
    );

    assign mem_resp = resp_r;
    assign busy     = busy_r;
    assign err      = err_r;

endmodule

// File: tb/tb_mp1_mem_responder.sv
// Randomized and directed bench for mp1_mem_responder against a transaction-level model.
module tb_mp1_mem_responder;
    import mp1_mem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk, rst, mem_read, mem_write, bd_we;
    be_t         mem_byte_enable;
    logic [31:0] mem_address;
    word_t       mem_wdata, bd_wdata;
    logic [9:0]  bd_addr;
    logic        mem_resp, busy, resp1, busy1;
    word_t       mem_rdata, rdata1;
    logic [2:0]  err, err1;

    word_t       mem_m [DEPTH];
    word_t       rdata_m;
    logic [2:0]  err_m;
    int          n_checks, n_pass, cyc, n_resp;

    mp1_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .bd_we(bd_we), .bd_addr(bd_addr),
        .bd_wdata(bd_wdata), .busy(busy), .err(err)
    );

    mp1_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(resp1), .mem_rdata(rdata1), .bd_we(bd_we), .bd_addr(bd_addr),
        .bd_wdata(bd_wdata), .busy(busy1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_resp) n_resp <= n_resp + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    function automatic word_t merge(input word_t old, input word_t nw, input be_t be);
        word_t r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; bd_we = 1'b0;
        tick();
        check("rst_resp", 32'(mem_resp), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        rst = 1'b1;
        err_m = 3'b000;
        rdata_m = 32'h0;
    endtask

    task automatic bd_write(input int idx, input word_t d);
        bd_we = 1'b1; bd_addr = 10'(idx); bd_wdata = d;
        tick();
        bd_we = 1'b0;
        mem_m[idx] = d;
    endtask

    // one complete handshake; leaves the responder idle on return
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input word_t wd, input be_t be, input bit hold, output int acc_edge);
        int lat;
        int idx;
        mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        tick();
        acc_edge = cyc;
        lat = 0;
        while (!mem_resp && lat < 20) begin
            tick();
            lat++;
            if (lat == 1) check("busy_wait", 32'(busy), 32'h1);
        end
        check("latency", 32'(lat), 32'(LAT));
        idx = widx(addr);
        if (rd && wr) begin
            err_m[0] = 1'b1;
            rdata_m = 32'h0;
        end else if (rd) begin
            rdata_m = mem_m[idx];
        end else begin
            mem_m[idx] = merge(mem_m[idx], wd, be);
        end
        check("rdata", mem_rdata, rdata_m);
        check("err", 32'(err), 32'(err_m));
        if (hold) begin
            tick();
            check("resp_once", 32'(mem_resp), 32'h0);
            check("busy_done", 32'(busy), 32'h0);
            mem_read = 1'b0; mem_write = 1'b0;
        end else begin
            mem_read = 1'b0; mem_write = 1'b0;
            tick();
        end
    endtask

    initial begin
        int a1, a2, r0, lat;
        logic [31:0] ra;
        int op, w;
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'h0;
        mem_address = 32'h0; mem_wdata = 32'h0; bd_we = 1'b0; bd_addr = 10'h0; bd_wdata = 32'h0;
        err_m = 3'b000; rdata_m = 32'h0;
        tick();
        do_reset();
        for (int i = 0; i < DEPTH; i++) bd_write(i, $urandom);

        bd_write(5, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b1, a1);
        check("read_word5", mem_rdata, 32'hDEADBEEF);

        bd_write(2, 32'h11223344);
        access(1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 1'b0, a1);
        access(1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, a1);
        check("be_merge", mem_rdata, 32'h11BB33DD);
        check("be_err", 32'(err), 32'h0);

        r0 = n_resp;
        access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b1, a1);
        access(1'b1, 1'b0, 32'h08, 32'h0, 4'h0, 1'b1, a2);
        check("b2b_accept", 32'(a2 - a1), 32'd5);
        check("b2b_resps", 32'(n_resp - r0), 32'd2);

        do_reset();
        bd_write(3, 32'h12345678);
        access(1'b1, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, 1'b1, a1);
        check("rw_err", 32'(err), 32'h1);
        check("rw_rdata", mem_rdata, 32'h0);
        access(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, a1);
        check("rw_nowrite", mem_rdata, 32'h12345678);

        do_reset();
        bd_write(4, 32'h44440004);
        bd_write(8, 32'h88880008);
        bd_write(7, 32'h77770007);
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h10;
        tick();
        mem_address = 32'h20; bd_we = 1'b1; bd_addr = 10'd7; bd_wdata = 32'hBAD0BAD0;
        tick();
        bd_we = 1'b0;
        lat = 1;
        while (!mem_resp && lat < 20) begin
            tick();
            lat++;
        end
        check("chg_latency", 32'(lat), 32'(LAT));
        check("chg_rdata", mem_rdata, 32'h44440004);
        check("chg_err", 32'(err), 32'h6);
        mem_read = 1'b0;
        tick();
        err_m = 3'b110;
        rdata_m = mem_m[4];
        access(1'b1, 1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, a1);
        check("bd_dropped", mem_rdata, 32'h77770007);

        do_reset();
        bd_write(9, 32'h99990009);
        mem_write = 1'b1; mem_read = 1'b0; mem_address = 32'h24;
        mem_wdata = 32'hFFFFFFFF; mem_byte_enable = 4'hF;
        tick(); tick(); tick();
        do_reset();
        access(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b0, a1);
        check("rst_nowrite", mem_rdata, 32'h99990009);

        bd_write(0, 32'h0BADCAFE);
        access(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, a1);
        check("wrap", mem_rdata, 32'h0BADCAFE);

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            w  = $urandom_range(0, 15);
            ra = (32'($urandom_range(0, 3)) << 12) | (32'(w) << 2) | 32'($urandom_range(0, 3));
            if (op < 2) bd_write(w, $urandom);
            else if (op < 6) access(1'b1, 1'b0, ra, $urandom, 4'($urandom), 1'($urandom), a1);
            else if (op < 9) access(1'b0, 1'b1, ra, $urandom, 4'($urandom), 1'($urandom), a1);
            else access(1'b1, 1'b1, ra, $urandom, 4'($urandom), 1'($urandom), a1);
            repeat ($urandom_range(0, 2)) tick();
        end

        do_reset();
        bd_write(6, 32'h66660006);
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h18;
        tick();
        tick();
        check("l1_resp", 32'(resp1), 32'h1);
        check("l1_rdata", rdata1, 32'h66660006);
        check("l1_busy", 32'(busy1), 32'h1);
        mem_read = 1'b0;
        tick();
        check("l1_resp_end", 32'(resp1), 32'h0);
        check("l1_err", 32'(err1), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
